// File: rtl/sine_envelope_shaper.sv
// ADSR amplitude envelope applied to a mid-scale-biased 10-bit sample stream via a serial shift-add multiplier.
// Optional build macro ENV_EXP_RELEASE_EN selects an exponential-like release tail instead of the linear step.
module sine_envelope_shaper #(
    parameter int TICK_DIV     = 1024,
    parameter int ATTACK_STEP  = 4,
    parameter int DECAY_STEP   = 1,
    parameter int SUSTAIN_LVL  = 160,
    parameter int RELEASE_STEP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [9:0] sample_in,
    input  logic       sample_valid,
    output logic [9:0] sample_out,
    output logic       sample_out_valid,
    output logic [7:0] env_level,
    output logic [2:0] env_state,
    output logic       busy
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    logic [CW-1:0] r_tick_cnt;
    logic          w_tick;
    logic          r_gate_q;
    logic          w_rise;
    logic          w_fall;
    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_env;
    logic [7:0]    w_env_next;
    logic [8:0]    w_att_sum;
    logic [8:0]    w_dec_diff;
    logic [8:0]    w_rel_dec;
    logic [8:0]    w_rel_diff;

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_rise = gate & ~r_gate_q;
    assign w_fall = ~gate & r_gate_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_gate_q   <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_gate_q   <= gate;
        end
    end

    // 9-bit step arithmetic: bit 8 flags overflow past 255 or underflow below 0.
    assign w_att_sum  = {1'b0, r_env} + 9'(ATTACK_STEP);
    assign w_dec_diff = {1'b0, r_env} - 9'(DECAY_STEP);
`ifdef ENV_EXP_RELEASE_EN
    assign w_rel_dec  = {5'd0, r_env[7:4]} + 9'd1;
`else
    assign w_rel_dec  = 9'(RELEASE_STEP);
`endif
    assign w_rel_diff = {1'b0, r_env} - w_rel_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_env   <= '0;
        end else begin
            r_state <= w_state_next;
            r_env   <= w_env_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_env_next   = r_env;
        if (w_rise) begin
            w_state_next = ST_ATTACK;
        end else if (w_fall) begin
            if (r_state == ST_ATTACK || r_state == ST_DECAY || r_state == ST_SUSTAIN)
                w_state_next = ST_RELEASE;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: w_env_next = '0;
                ST_ATTACK: begin
                    if (w_att_sum >= 9'd255) begin
                        w_env_next   = 8'd255;
                        w_state_next = ST_DECAY;
                    end else begin
                        w_env_next = w_att_sum[7:0];
                    end
                end
                ST_DECAY: begin
                    if (w_dec_diff[8] || (w_dec_diff <= 9'(SUSTAIN_LVL))) begin
                        w_env_next   = 8'(SUSTAIN_LVL);
                        w_state_next = ST_SUSTAIN;
                    end else begin
                        w_env_next = w_dec_diff[7:0];
                    end
                end
                ST_RELEASE: begin
                    if (w_rel_diff[8] || (w_rel_diff == 9'd0)) begin
                        w_env_next   = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_env_next = w_rel_diff[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    logic               r_busy;
    logic [3:0]         r_cnt;
    logic signed [18:0] r_acc;
    logic signed [18:0] r_mcand;
    logic [7:0]         r_mplier;
    logic [9:0]         r_result;
    logic [9:0]         r_sample_out;
    logic               r_out_valid;
    logic signed [10:0] w_s;
    logic signed [18:0] w_addend;
    logic signed [18:0] w_scaled;
    logic signed [19:0] w_sum;
    logic [9:0]         w_clamped;

    assign w_s      = $signed({1'b0, sample_in} - 11'd512);
    assign w_addend = r_mplier[0] ? r_mcand : 19'sd0;
    assign w_scaled = r_acc >>> 8;
    assign w_sum    = {w_scaled[18], w_scaled} + 20'sd512;

    always_comb begin
        w_clamped = w_sum[9:0];
        if (w_sum[19])
            w_clamped = 10'd0;
        else if (w_sum > 20'sd1023)
            w_clamped = 10'd1023;
    end

    // Cycles 0..7 accumulate one envelope bit each, 8 rescales, 9 publishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= 1'b0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_result     <= 10'd512;
            r_sample_out <= 10'd512;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (!r_busy) begin
                if (sample_valid) begin
                    r_busy   <= 1'b1;
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    r_mcand  <= {{8{w_s[10]}}, w_s};
                    r_mplier <= r_env;
                end
            end else begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt < 4'd8) begin
                    r_acc    <= r_acc + w_addend;
                    r_mcand  <= r_mcand <<< 1;
                    r_mplier <= r_mplier >> 1;
                end else if (r_cnt == 4'd8) begin
                    r_result <= w_clamped;
                end else begin
                    r_sample_out <= r_result;
                    r_out_valid  <= 1'b1;
                    r_busy       <= 1'b0;
                end
            end
        end
    end

    assign sample_out       = r_sample_out;
    assign sample_out_valid = r_out_valid;
    assign env_level        = r_env;
    assign env_state        = r_state;
    assign busy             = r_busy;

endmodule

// File: tb/tb_sine_envelope_shaper.sv
// Directed + randomized bench for sine_envelope_shaper against a cycle-level behavioural model.
module tb_sine_envelope_shaper;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic       gate;
    logic [9:0] sample_in;
    logic       sample_valid;
    logic [9:0] sample_out;
    logic       sample_out_valid;
    logic [7:0] env_level;
    logic [2:0] env_state;
    logic       busy;

    sine_envelope_shaper #(.TICK_DIV(TD)) dut (
        .clk              (clk),
        .rst              (rst),
        .gate             (gate),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .env_level        (env_level),
        .env_state        (env_state),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_env, m_st, m_idx, m_rem, m_pend, m_out, ticks;
    bit m_gq, m_busy, m_valid, rand_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic m_reset();
        m_env = 0; m_st = 0; m_idx = 0; m_rem = 0; m_pend = 0; m_out = 512;
        m_gq = 0; m_busy = 0; m_valid = 0;
    endtask

    task automatic cyc();
        bit tk, g, rise, fall;
        int e_old, s, v;
        @(posedge clk);
        g  = (gate === 1'b1);
        tk = ((m_idx % TD) == TD - 1);
        m_idx++;
        if (tk) ticks++;
        rise  = g && !m_gq;
        fall  = !g && m_gq;
        e_old = m_env;
        if (rise) m_st = 1;
        else if (fall) begin
            if (m_st >= 1 && m_st <= 3) m_st = 4;
        end else if (tk) begin
            case (m_st)
                0: m_env = 0;
                1: begin m_env = m_env + 4; if (m_env >= 255) begin m_env = 255; m_st = 2; end end
                2: begin m_env = m_env - 1; if (m_env <= 160) begin m_env = 160; m_st = 3; end end
                4: begin
`ifdef ENV_EXP_RELEASE_EN
                    m_env = m_env - (m_env / 16 + 1);
`else
                    m_env = m_env - 2;
`endif
                    if (m_env <= 0) begin m_env = 0; m_st = 0; end
                end
                default: ;
            endcase
        end
        m_gq = g;
        m_valid = 0;
        if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin m_out = m_pend; m_valid = 1; m_busy = 0; end
        end else if (sample_valid === 1'b1) begin
            s = int'(sample_in) - 512;
            v = 512 + ((s * e_old) >>> 8);
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            m_pend = v; m_busy = 1; m_rem = 10;
        end
        #1;
        check("env_level", env_level, m_env);
        check("env_state", env_state, m_st);
        check("busy", busy, m_busy);
        check("out_valid", sample_out_valid, m_valid);
        check("sample_out", sample_out, m_out);
        sample_valid = 1'b0;
    endtask

    task automatic step();
        if (rand_en && $urandom_range(0, 3) == 0) begin
            sample_valid = 1'b1;
            sample_in    = 10'($urandom_range(0, 1023));
        end
        cyc();
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 4000 && ticks < target; i++) step();
    endtask

    task automatic run_sample(input logic [9:0] v, input int expv, input string tag);
        int lat;
        for (int i = 0; i < 20 && m_busy; i++) cyc();
        sample_valid = 1'b1;
        sample_in    = v;
        cyc();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            lat++;
            if (sample_out_valid === 1'b1) break;
        end
        check({tag, "_latency"}, lat, 10);
        check(tag, sample_out, expv);
        cyc();
        check({tag, "_pulse"}, sample_out_valid, 0);
    endtask

    initial begin
        int e_hold, nv;
        rst = 1'b1; gate = 1'b0; sample_valid = 1'b0; sample_in = '0;
        rand_en = 0; ticks = 0;
        #22;
        check("rst_out", sample_out, 512);
        check("rst_valid", sample_out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_env", env_level, 0);
        check("rst_state", env_state, 0);
        m_reset();
        @(negedge clk) rst = 1'b0;

        // idle gain
        run_sample(10'd1023, 512, "idle_gain");
        check("idle_state", env_state, 0);

        // attack to 255 then decay to sustain
        gate = 1'b1;
        cyc();
        check("attack_enter", env_state, 1);
        ticks = 0;
        run_until(64);
        check("attack_peak_env", env_level, 255);
        check("attack_peak_state", env_state, 2);
        run_sample(10'd1023, 1021, "gain_max_hi");
        rand_en = 1;
        run_until(64 + 95);
        check("sustain_env", env_level, 160);
        check("sustain_state", env_state, 3);
        run_until(64 + 95 + 6);
        check("sustain_hold", env_level, 160);

        // release
        gate = 1'b0;
        cyc();
        check("release_enter", env_state, 4);
        check("release_env0", env_level, 160);
        ticks = 0;
`ifdef ENV_EXP_RELEASE_EN
        run_until(1);
        check("release_exp_first", env_level, 149);
`else
        run_until(79);
        check("release_79_env", env_level, 2);
        check("release_79_state", env_state, 4);
`endif
        run_until(80);
        check("release_done_env", env_level, 0);
        check("release_done_state", env_state, 0);

        // second attack: low and mid-scale samples at full gain
        rand_en = 0;
        gate = 1'b1;
        cyc();
        ticks = 0;
        run_until(64);
        check("attack2_env", env_level, 255);
        run_sample(10'd0, 2, "gain_max_lo");
        run_sample(10'd512, 512, "gain_mid");
        rand_en = 1;
        run_until(64 + 95);
        check("sustain2_state", env_state, 3);

        // retrigger from release
        gate = 1'b0;
        cyc();
        for (int i = 0; i < 2000 && m_env > 100; i++) step();
`ifndef ENV_EXP_RELEASE_EN
        check("retrig_at100", env_level, 100);
`endif
        e_hold = m_env;
        gate = 1'b1;
        cyc();
        check("retrig_state", env_state, 1);
        check("retrig_hold", env_level, e_hold);
        ticks = 0;
        run_until(1);
        check("retrig_step", env_level, e_hold + 4);

        // fall coinciding with a tick
        for (int i = 0; i < 10 && (m_idx % TD) != TD - 1; i++) cyc();
        e_hold = m_env;
        gate = 1'b0;
        cyc();
        check("fall_tick_state", env_state, 4);
        check("fall_tick_env", env_level, e_hold);

        // overrun: second strobe 3 cycles later is dropped
        rand_en = 0;
        for (int i = 0; i < 20 && m_busy; i++) cyc();
        sample_valid = 1'b1; sample_in = 10'($urandom_range(0, 1023));
        cyc(); cyc(); cyc();
        sample_valid = 1'b1; sample_in = 10'($urandom_range(0, 1023));
        cyc();
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (sample_out_valid === 1'b1) nv++;
        end
        check("overrun_count", nv, 1);

        // reset in the middle of a multiply
        sample_valid = 1'b1; sample_in = 10'd900;
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1;
        #2;
        check("abort_out", sample_out, 512);
        check("abort_valid", sample_out_valid, 0);
        check("abort_busy", busy, 0);
        m_reset();
        @(negedge clk) rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (sample_out_valid === 1'b1) nv++;
        end
        check("abort_no_valid", nv, 0);

        // random gate activity and samples
        rand_en = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) gate = ~gate;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sine_envelope_shaper.md
Name: sine_envelope_shaper

Overview:
Amplitude-envelope stage sitting directly downstream of the sine synthesizer and upstream of the PWM audio DAC. It takes the synthesizer's 10-bit unsigned, mid-scale-biased sample stream plus a note gate. It applies an attack/decay/sustain/release (ADSR) envelope so notes fade in and out instead of starting and stopping abruptly. The result is a scaled 10-bit sample for the PWM stage. Scaling uses a serial shift-add multiplier to keep tile area small.

Parameters:
TICK_DIV, 1024, clk cycles per envelope step (legal range 2..65536)
ATTACK_STEP, 4, envelope increment per tick in ATTACK
DECAY_STEP, 1, envelope decrement per tick in DECAY
SUSTAIN_LVL, 160, sustain level (0..255)
RELEASE_STEP, 2, envelope decrement per tick in RELEASE (linear mode)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
gate  input  1  note active (synth input word non-zero); synchronous to clk
sample_in  input  10  unsigned sample, mid-scale 512
sample_valid  input  1  one-cycle strobe, sample_in valid
sample_out  output  10  scaled unsigned sample, mid-scale 512
sample_out_valid  output  1  one-cycle strobe, sample_out updated
env_level  output  8  current envelope level
env_state  output  3  FSM state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
busy  output  1  multiplier in progress

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: env_level=0, env_state=IDLE, sample_out=512, sample_out_valid=0, busy=0. Tick counter=0, gate_q=0.
- Tick: counter runs 0..TICK_DIV-1 and wraps. Tick pulses for one cycle on the wrap. The counter is free-running and unaffected by gate.
- Edges: gate_q is gate delayed one cycle. rise = gate & ~gate_q; fall = ~gate & gate_q.
- FSM transitions:
  - Any state, rise: go to ATTACK. Envelope keeps its current level (retrigger, no click).
  - ATTACK/DECAY/SUSTAIN, fall: go to RELEASE.
  - ATTACK, tick: env += ATTACK_STEP, saturating at 255. When it reaches 255, go to DECAY.
  - DECAY, tick: env -= DECAY_STEP, floored at SUSTAIN_LVL. When it reaches SUSTAIN_LVL, go to SUSTAIN.
  - SUSTAIN: env holds.
  - RELEASE, tick: env -= RELEASE_STEP, saturating at 0. When it reaches 0, go to IDLE.
  - IDLE: env=0.
- Priority: an edge in the same cycle as a tick wins; no step is applied that cycle.
- Arithmetic: env steps are computed in 9 bits, then saturated. There is no wrap-around at any step size.
- Scaling:
  - On sample_valid with busy=0, latch s = sample_in - 512 (11-bit signed) and e = env_level. Set busy=1.
  - Over 8 cycles, run a serial shift-add of s*e, one env bit per cycle, LSB first, with a 19-bit signed accumulator.
  - Then compute 512 + (product >>> 8), arithmetic shift (floor), and clamp to 0..1023.
  - Latency: sample_out and sample_out_valid update exactly 10 cycles after the sample_valid cycle. busy clears in the same cycle.
- Gain: env=255 gives a gain of 255/256. env=0 gives 512 exactly.
- Overrun: sample_valid while busy=1 is ignored. No queueing; sample_out holds its previous value.
- Envelope changes during a multiply do not affect the in-flight result, which uses the latched e.
- Reset mid-multiply aborts it. No sample_out_valid is generated for the aborted sample.

Optional Feature:
ENV_EXP_RELEASE_EN. Defined: RELEASE step is env -= (env>>4)+1, saturating at 0, giving an exponential-like tail; RELEASE_STEP is unused. Undefined: linear RELEASE_STEP as above. All other states are identical in both builds.

Test Plan:
- Reset then idle: hold rst=1, release, send sample_valid with sample_in=1023 -> sample_out=512 after 10 cycles, env_state=0, env_level=0.
- Attack/decay with TICK_DIV=4, gate=1 held: env_level reaches 255 at tick 64 -> state DECAY. After 95 further ticks, env=160 and state=SUSTAIN, then holds.
- Scaling at env=255: sample_in=1023 -> 1021; sample_in=0 -> 2; sample_in=512 -> 512. sample_out_valid is high for exactly one cycle, 10 cycles after the strobe.
- Release, linear build: drop gate in SUSTAIN (env=160) -> state RELEASE, reaching 0 and IDLE after 80 ticks. Built with ENV_EXP_RELEASE_EN, the first step gives env 160 -> 149.
- Retrigger and priority: raise gate in RELEASE at env=100 -> ATTACK from 100, next tick gives 104. Fall coinciding with a tick -> RELEASE with env unchanged that cycle.
- Overrun and reset abort:
  - Two sample_valid strobes 3 cycles apart -> only the first produces output.
  - Assert rst at cycle 5 of a multiply -> no sample_out_valid, and sample_out=512.
